// File: rtl/serial_sub_pkg.sv
// Shared definitions for the bit-serial subtractor: controller state encoding
// and the bit-counter width helper.
package serial_sub_pkg;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        RUN  = 2'd1,
        DONE = 2'd2
    } state_t;

    // At least one bit, so the counter stays legal at the narrowest width.
    function automatic int cnt_width(input int w);
        return (w > 2) ? $clog2(w) : 1;
    endfunction

endpackage

// File: rtl/full_subtractor.sv
// Single-bit full subtractor cell: d = a - b - bin, with borrow out.
module full_subtractor (
    input  logic a,
    input  logic b,
    input  logic bin,
    output logic d,
    output logic bout
);

    assign d    = a ^ b ^ bin;
    assign bout = (~a & b) | (~(a ^ b) & bin);

endmodule

// File: rtl/serial_subtractor_ctrl.sv
// Bit-serial A - B - bin controller reusing one full_subtractor over WIDTH cycles, LSB first.
// Optional signed-overflow flag port ovf is enabled by defining SERIAL_SUB_OVERFLOW_EN.
module serial_subtractor_ctrl
    import serial_sub_pkg::*;
#(
    parameter int WIDTH = 8
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             start,
    input  logic [WIDTH-1:0] a_in,
    input  logic [WIDTH-1:0] b_in,
    input  logic             bin_in,
    output logic             busy,
    output logic             done,
    output logic [WIDTH-1:0] diff,
    output logic             bout
`ifdef SERIAL_SUB_OVERFLOW_EN
    ,
    output logic             ovf
`endif
);

    localparam int CW = cnt_width(WIDTH);

    state_t           state;
    state_t           state_next;
    logic [WIDTH-1:0] a_sr;
    logic [WIDTH-1:0] b_sr;
    logic [WIDTH-1:0] diff_r;
    logic [CW-1:0]    cnt;
    logic             borrow_r;
    logic             bout_r;
    logic             fs_d;
    logic             fs_bout;
    logic             last_bit;
`ifdef SERIAL_SUB_OVERFLOW_EN
    logic             a_msb;
    logic             b_msb;
    logic             ovf_r;
`endif

    full_subtractor u_cell (
        .a    (a_sr[0]),
        .b    (b_sr[0]),
        .bin  (borrow_r),
        .d    (fs_d),
        .bout (fs_bout)
    );

    assign last_bit = (cnt == CW'(WIDTH - 1));

    always_comb begin
        state_next = state;
        busy       = 1'b0;
        done       = 1'b0;
        case (state)
            IDLE: begin
                if (start) state_next = RUN;
            end
            RUN: begin
                busy = 1'b1;
                if (last_bit) state_next = DONE;
            end
            DONE: begin
                done       = 1'b1;
                state_next = start ? RUN : IDLE;
            end
            default: state_next = IDLE;
        endcase
    end

    // Operands load only on an accepted start; the result registers move only in RUN.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state    <= IDLE;
            a_sr     <= '0;
            b_sr     <= '0;
            diff_r   <= '0;
            cnt      <= '0;
            borrow_r <= 1'b0;
            bout_r   <= 1'b0;
`ifdef SERIAL_SUB_OVERFLOW_EN
            a_msb    <= 1'b0;
            b_msb    <= 1'b0;
            ovf_r    <= 1'b0;
`endif
        end else begin
            state <= state_next;
            case (state)
                IDLE, DONE: begin
                    if (start) begin
                        a_sr     <= a_in;
                        b_sr     <= b_in;
                        borrow_r <= bin_in;
                        cnt      <= '0;
`ifdef SERIAL_SUB_OVERFLOW_EN
                        a_msb    <= a_in[WIDTH-1];
                        b_msb    <= b_in[WIDTH-1];
                        ovf_r    <= 1'b0;
`endif
                    end
                end
                RUN: begin
                    diff_r   <= {fs_d, diff_r[WIDTH-1:1]};
                    borrow_r <= fs_bout;
                    a_sr     <= a_sr >> 1;
                    b_sr     <= b_sr >> 1;
                    cnt      <= cnt + CW'(1);
                    if (last_bit) begin
                        bout_r <= fs_bout;
`ifdef SERIAL_SUB_OVERFLOW_EN
                        // fs_d here is the result MSB being shifted in on this edge.
                        ovf_r  <= (a_msb != b_msb) && (fs_d != a_msb);
`endif
                    end
                end
                default: ;
            endcase
        end
    end

    assign diff = diff_r;
    assign bout = bout_r;
`ifdef SERIAL_SUB_OVERFLOW_EN
    assign ovf  = ovf_r;
`endif

endmodule

// File: tb/tb_serial_subtractor_ctrl.sv
// Directed self-checking bench for serial_subtractor_ctrl: WIDTH=8 vectors plus an
// exhaustive WIDTH=2 sweep; overflow vectors build when SERIAL_SUB_OVERFLOW_EN is defined.
module tb_serial_subtractor_ctrl;

    logic       clk = 1'b0;
    logic       rst_n;
    logic       start;
    logic [7:0] a_in;
    logic [7:0] b_in;
    logic       bin_in;
    logic       busy;
    logic       done;
    logic [7:0] diff;
    logic       bout;
    logic       ovf;

    logic       start2;
    logic [1:0] a2;
    logic [1:0] b2;
    logic       bin2;
    logic       busy2;
    logic       done2;
    logic [1:0] diff2;
    logic       bout2;
    logic       ovf2;

    int passCount = 0;
    int checkCount = 0;

    always #5 clk = ~clk;

    serial_subtractor_ctrl #(.WIDTH(8)) dut8 (
        .clk    (clk),
        .rst_n  (rst_n),
        .start  (start),
        .a_in   (a_in),
        .b_in   (b_in),
        .bin_in (bin_in),
        .busy   (busy),
        .done   (done),
        .diff   (diff),
        .bout   (bout)
`ifdef SERIAL_SUB_OVERFLOW_EN
        ,
        .ovf    (ovf)
`endif
    );

    serial_subtractor_ctrl #(.WIDTH(2)) dut2 (
        .clk    (clk),
        .rst_n  (rst_n),
        .start  (start2),
        .a_in   (a2),
        .b_in   (b2),
        .bin_in (bin2),
        .busy   (busy2),
        .done   (done2),
        .diff   (diff2),
        .bout   (bout2)
`ifdef SERIAL_SUB_OVERFLOW_EN
        ,
        .ovf    (ovf2)
`endif
    );

`ifndef SERIAL_SUB_OVERFLOW_EN
    assign ovf  = 1'b0;
    assign ovf2 = 1'b0;
`endif

    task automatic checkOutput(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checkCount++;
        if (got === exp) passCount++;
        else $display("[TB] FAIL %s: got %0d, expected %0d", tag, got, exp);
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    // Presents one operation and lets the accepting edge pass; start stays high if hold is set.
    task automatic applyStimulus(input logic [7:0] a, input logic [7:0] b, input logic bin, input bit hold);
        a_in   = a;
        b_in   = b;
        bin_in = bin;
        start  = 1'b1;
        tick();
        start  = hold;
    endtask

    task automatic waitDone8(output int edges, output int busyCycles);
        edges      = 0;
        busyCycles = 0;
        while (!done && edges < 20) begin
            if (busy) busyCycles++;
            tick();
            edges++;
        end
    endtask

    task automatic runOp8(input string tag, input logic [7:0] a, input logic [7:0] b, input logic bin,
                          input logic [7:0] expDiff, input logic expBout);
        int edges;
        int busyCycles;
        applyStimulus(a, b, bin, 1'b0);
        waitDone8(edges, busyCycles);
        checkOutput({tag, "_latency"}, edges, 8);
        checkOutput({tag, "_busy_cycles"}, busyCycles, 8);
        checkOutput({tag, "_diff"}, diff, expDiff);
        checkOutput({tag, "_bout"}, bout, expBout);
        checkOutput({tag, "_busy_in_done"}, busy, 0);
    endtask

    initial begin
        int edges;
        int busyCycles;
        int doneSeen;
        rst_n  = 1'b0;
        start  = 1'b0;
        a_in   = '0;
        b_in   = '0;
        bin_in = 1'b0;
        start2 = 1'b0;
        a2     = '0;
        b2     = '0;
        bin2   = 1'b0;
        tick();
        tick();
        checkOutput("rst_busy", busy, 0);
        checkOutput("rst_done", done, 0);
        checkOutput("rst_diff", diff, 0);
        checkOutput("rst_bout", bout, 0);
        checkOutput("rst_ovf", ovf, 0);
        rst_n = 1'b1;
        tick();

        runOp8("op100_37", 8'd100, 8'd37, 1'b0, 8'd63, 1'b0);
        tick();
        checkOutput("done_one_cycle", done, 0);
        tick();
        tick();
        checkOutput("diff_held_idle", diff, 63);
        checkOutput("bout_held_idle", bout, 0);

        runOp8("op5_10", 8'd5, 8'd10, 1'b0, 8'd251, 1'b1);
        tick();
        runOp8("op0_0_b1", 8'd0, 8'd0, 1'b1, 8'd255, 1'b1);
        tick();

        // Start held through RUN with new operands: first result intact, second accepted in DONE.
        applyStimulus(8'd100, 8'd37, 1'b0, 1'b1);
        a_in = 8'd200;
        b_in = 8'd1;
        waitDone8(edges, busyCycles);
        checkOutput("hold_first_diff", diff, 63);
        checkOutput("hold_first_bout", bout, 0);
        tick();
        start = 1'b0;
        checkOutput("b2b_busy", busy, 1);
        waitDone8(edges, busyCycles);
        checkOutput("b2b_gap", edges + 1, 9);
        checkOutput("b2b_diff", diff, 199);
        checkOutput("b2b_bout", bout, 0);
        tick();

        // Abort mid-run at cnt=4.
        applyStimulus(8'd50, 8'd20, 1'b0, 1'b0);
        repeat (4) tick();
        rst_n = 1'b0;
        tick();
        rst_n = 1'b1;
        checkOutput("abort_busy", busy, 0);
        checkOutput("abort_diff", diff, 0);
        checkOutput("abort_bout", bout, 0);
        doneSeen = 0;
        for (int i = 0; i < 12; i++) begin
            if (done || busy) doneSeen++;
            tick();
        end
        checkOutput("abort_no_done", doneSeen, 0);
        runOp8("after_abort", 8'd50, 8'd20, 1'b0, 8'd30, 1'b0);
        tick();

        // Reset wins over a simultaneous start.
        rst_n = 1'b0;
        a_in  = 8'd9;
        start = 1'b1;
        tick();
        rst_n = 1'b1;
        start = 1'b0;
        checkOutput("rst_prio_busy", busy, 0);
        checkOutput("rst_prio_diff", diff, 0);
        tick();
        checkOutput("rst_prio_idle", busy, 0);

`ifdef SERIAL_SUB_OVERFLOW_EN
        runOp8("ovf80_01", 8'h80, 8'h01, 1'b0, 8'h7F, 1'b0);
        checkOutput("ovf80_01_flag", ovf, 1);
        tick();
        applyStimulus(8'h05, 8'h03, 1'b0, 1'b0);
        checkOutput("ovf_clear_on_start", ovf, 0);
        waitDone8(edges, busyCycles);
        checkOutput("ovf05_03_diff", diff, 2);
        checkOutput("ovf05_03_flag", ovf, 0);
        tick();
`endif

        // Exhaustive WIDTH=2 sweep with exact done timing.
        for (int a = 0; a < 4; a++) begin
            for (int b = 0; b < 4; b++) begin
                for (int c = 0; c < 2; c++) begin
                    int expect3;
                    int early;
                    expect3 = (a - b - c) & 7;
                    a2     = 2'(a);
                    b2     = 2'(b);
                    bin2   = c[0];
                    start2 = 1'b1;
                    tick();
                    start2 = 1'b0;
                    early  = int'(done2) + (busy2 ? 0 : 2);
                    tick();
                    early  = early + int'(done2);
                    tick();
                    checkOutput($sformatf("w2_timing_%0d_%0d_%0d", a, b, c), {early[29:0], done2}, 1);
                    checkOutput($sformatf("w2_value_%0d_%0d_%0d", a, b, c), {bout2, diff2}, expect3);
                    tick();
                end
            end
        end

        $display("%0d/%0d checks passed", passCount, checkCount);
        $finish;
    end

endmodule
